// File: rtl/ip_csum_sched_pkg.sv
// Shared types for the checksum-engine scheduler: FSM encoding, engine beat, engine constants.
package ip_csum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_FEED = 3'd2,
        ST_PAD  = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam int unsigned CSUM_LAT_DEF = 2;
    localparam logic [15:0] CSUM_EMPTY   = 16'hFFFF;

    // One byte presented to the checksum engine with its strobes
    typedef struct packed {
        logic       dv_even;
        logic       dv_odd;
        logic [7:0] data;
    } csum_beat_t;

endpackage

// File: rtl/ip_csum_sched_if.sv
// Client + engine bundle of the checksum scheduler; abort exists only with IP_CSUM_SCHED_ABORT_EN.
interface ip_csum_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 11
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ*8-1:0]     req_data;
    logic [N_REQ-1:0]       gnt;
    logic                   rd_en;
    logic                   csum_reset;
    logic                   csum_dv_even;
    logic                   csum_dv_odd;
    logic [7:0]             csum_data;
    logic [15:0]            csum_result;
    logic [15:0]            result;
    logic [N_REQ-1:0]       done;
    logic                   busy;
`ifdef IP_CSUM_SCHED_ABORT_EN
    logic                   abort;
`endif

    modport master (
        input  req, req_len, req_data, csum_result,
        output gnt, rd_en, csum_reset, csum_dv_even, csum_dv_odd, csum_data,
               result, done, busy
`ifdef IP_CSUM_SCHED_ABORT_EN
        , output abort
`endif
    );

    modport slave (
        output req, req_len, req_data, csum_result,
        input  gnt, rd_en, csum_reset, csum_dv_even, csum_dv_odd, csum_data,
               result, done, busy
`ifdef IP_CSUM_SCHED_ABORT_EN
        , input abort
`endif
    );

endinterface

// File: rtl/ip_csum_sched_rr_arb.sv
// Round-robin priority encoder; the pointer advances past the winner whenever a grant is loaded.
module ip_csum_rr_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_load,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // First requester at or after the pointer, wrapping
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'((32'(r_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= IDX_W'((32'(o_idx) + 1) % N_REQ);
        end
    end

endmodule

// File: rtl/ip_csum_sched.sv
// Shares one 8-bit ones'-complement checksum engine among N_REQ clients in round-robin order.
// Optional build macro IP_CSUM_SCHED_ABORT_EN: a client dropping req before WAIT aborts its job.
module ip_csum_sched
    import ip_csum_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned LEN_W    = 11,
    parameter int unsigned CSUM_LAT = CSUM_LAT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    ip_csum_sched_if.master io_bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned LAT_W = $clog2(CSUM_LAT + 1);

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, r_done, w_arb_gnt;
    logic [IDX_W-1:0] r_idx, w_arb_idx;
    logic [LEN_W-1:0] r_cnt;
    logic             r_odd;
    logic [LAT_W-1:0] r_lat;
    logic [15:0]      r_result;
    logic             w_load, w_rd_en;
    csum_beat_t       w_beat;
    logic [LEN_W-1:0] w_len_arr  [N_REQ];
    logic [7:0]       w_data_arr [N_REQ];
`ifdef IP_CSUM_SCHED_ABORT_EN
    logic             r_abort, w_abort;
`endif

    ip_csum_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .i_req  (io_bus.req),
        .i_load (w_load),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx)
    );

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_len_arr[k]  = io_bus.req_len[k*LEN_W +: LEN_W];
            w_data_arr[k] = io_bus.req_data[k*8 +: 8];
        end
    end

    // Next state and per-state engine strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rd_en     = 1'b0;
        w_beat      = '0;
`ifdef IP_CSUM_SCHED_ABORT_EN
        w_abort     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (io_bus.req != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CLR;
                end
            end
            ST_CLR:  w_state_nxt = (w_len_arr[r_idx] == '0) ? ST_WAIT : ST_FEED;
            ST_FEED: begin
                w_rd_en        = 1'b1;
                w_beat.data    = w_data_arr[r_idx];
                w_beat.dv_even = ~r_odd;
                w_beat.dv_odd  = r_odd;
                if (r_cnt == LEN_W'(1)) w_state_nxt = r_odd ? ST_WAIT : ST_PAD;
            end
            ST_PAD: begin
                w_beat.dv_odd = 1'b1;
                w_state_nxt   = ST_WAIT;
            end
            ST_WAIT: if (r_lat == '0) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
`ifdef IP_CSUM_SCHED_ABORT_EN
        // Client withdrew before the engine finished consuming its bytes
        if ((r_state == ST_CLR || r_state == ST_FEED || r_state == ST_PAD) && !io_bus.req[r_idx]) begin
            w_state_nxt = ST_IDLE;
            w_abort     = 1'b1;
            w_rd_en     = 1'b0;
            w_beat      = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_idx    <= '0;
            r_done   <= '0;
            r_cnt    <= '0;
            r_odd    <= 1'b0;
            r_lat    <= LAT_W'(CSUM_LAT - 1);
            r_result <= 16'h0000;
`ifdef IP_CSUM_SCHED_ABORT_EN
            r_abort  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_gnt <= w_arb_gnt;
                r_idx <= w_arb_idx;
            end else if (w_state_nxt == ST_IDLE) begin
                r_gnt <= '0;
            end
            r_done <= (r_state == ST_DONE) ? r_gnt : '0;
            if (r_state == ST_DONE) r_result <= io_bus.csum_result;
            if (r_state == ST_CLR) begin
                r_cnt <= w_len_arr[r_idx];
                r_odd <= 1'b0;
            end else if (r_state == ST_FEED) begin
                r_cnt <= r_cnt - LEN_W'(1);
                r_odd <= ~r_odd;
            end
            r_lat <= (r_state == ST_WAIT) ? r_lat - LAT_W'(1) : LAT_W'(CSUM_LAT - 1);
`ifdef IP_CSUM_SCHED_ABORT_EN
            r_abort <= w_abort;
`endif
        end
    end

    assign io_bus.gnt          = r_gnt;
    assign io_bus.done         = r_done;
    assign io_bus.result       = r_result;
    assign io_bus.busy         = (r_state != ST_IDLE);
    assign io_bus.rd_en        = w_rd_en;
    assign io_bus.csum_reset   = reset | (r_state == ST_CLR);
    assign io_bus.csum_dv_even = w_beat.dv_even;
    assign io_bus.csum_dv_odd  = w_beat.dv_odd;
    assign io_bus.csum_data    = w_beat.data;
`ifdef IP_CSUM_SCHED_ABORT_EN
    assign io_bus.abort        = r_abort;
`endif

endmodule

// File: tb/tb_ip_csum_sched.sv
// Scoreboard bench for ip_csum_sched with a behavioural 8-bit checksum engine and scripted clients.
module tb_ip_csum_sched;
    import ip_csum_pkg::*;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned LEN_W    = 11;
    localparam int unsigned CSUM_LAT = 2;

    typedef struct packed {
        logic [N_REQ-1:0] done;
        logic [15:0]      result;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ip_csum_sched_if #(.N_REQ(N_REQ), .LEN_W(LEN_W)) bus ();

    ip_csum_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .CSUM_LAT(CSUM_LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.master)
    );

    exp_t       exp_q [$];
    csum_beat_t beat_q[$];
    exp_t       m_e;
    csum_beat_t m_b, m_act;
    int         checks = 0;
    int         errors = 0;
    int         abort_cnt = 0;
    bit         chk_strobe = 1'b0;

    logic [N_REQ-1:0] pend;
    logic [7:0]       cbytes [N_REQ][32];
    logic [4:0]       cptr   [N_REQ];
    logic [LEN_W-1:0] clen   [N_REQ];
    logic [7:0]       eng_hi;
    logic [15:0]      eng_sum, eng_res;

    // Clients: byte stream restarts whenever the client is not granted
    assign bus.req = pend;
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_len[i*LEN_W +: LEN_W] = clen[i];
            bus.req_data[i*8 +: 8]        = cbytes[i][cptr[i]];
        end
    end
    always @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.gnt[i] !== 1'b1) cptr[i] <= 5'd0;
            else if (bus.rd_en)      cptr[i] <= cptr[i] + 5'd1;
        end
    end

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = 17'(a) + 17'(b);
        return s[15:0] + 16'(s[16]);
    endfunction

    // Engine: accumulate on dv_odd, result registered once more (two-cycle latency)
    always @(posedge clk) begin
        if (bus.csum_reset) begin
            eng_hi  <= 8'h00;
            eng_sum <= 16'h0000;
        end else begin
            if (bus.csum_dv_even) eng_hi  <= bus.csum_data;
            if (bus.csum_dv_odd)  eng_sum <= oc_add(eng_sum, {eng_hi, bus.csum_data});
        end
        eng_res <= ~eng_sum;
    end
    assign bus.csum_result = eng_res;

    // Monitor
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.done !== '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected actual done=%b result=%h required=no done", bus.done, bus.result);
                end else begin
                    m_e = exp_q.pop_front();
                    if (bus.done !== m_e.done || bus.result !== m_e.result) begin
                        errors++;
                        $display("FAIL done_result actual done=%b result=%h required done=%b result=%h",
                                 bus.done, bus.result, m_e.done, m_e.result);
                    end
                end
            end
            if (chk_strobe && (bus.csum_dv_even === 1'b1 || bus.csum_dv_odd === 1'b1)) begin
                checks++;
                m_act = '{dv_even: bus.csum_dv_even, dv_odd: bus.csum_dv_odd, data: bus.csum_data};
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected actual=%h required=none", m_act);
                end else begin
                    m_b = beat_q.pop_front();
                    if (m_act !== m_b) begin
                        errors++;
                        $display("FAIL beat actual even=%b odd=%b data=%h required even=%b odd=%b data=%h",
                                 m_act.dv_even, m_act.dv_odd, m_act.data, m_b.dv_even, m_b.dv_odd, m_b.data);
                    end
                end
            end
`ifdef IP_CSUM_SCHED_ABORT_EN
            if (bus.abort === 1'b1) abort_cnt++;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request from an idle scheduler and check req->done latency
    task automatic run_xfer(input int c, input int len, input logic [15:0] exp_res);
        int  cyc;
        bit  got;
        clen[c] = LEN_W'(len);
        if (chk_strobe) begin
            for (int k = 0; k < len; k++)
                beat_q.push_back('{dv_even: (k % 2 == 0), dv_odd: (k % 2 == 1), data: cbytes[c][k]});
            if (len % 2 == 1) beat_q.push_back('{dv_even: 1'b0, dv_odd: 1'b1, data: 8'h00});
        end
        exp_q.push_back('{done: N_REQ'(1 << c), result: exp_res});
        @(negedge clk);
        pend[c] = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (bus.done[c] === 1'b1) got = 1'b1;
        end
        pend[c] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout client=%0d actual=no done required=done", c);
        end else begin
            chk("latency", 32'(cyc), 32'(3 + len + (len % 2) + CSUM_LAT));
        end
    endtask

    // Wait (bounded) until the given client has had n bytes consumed
    task automatic wait_bytes(input int c, input int n);
        int seen, cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt[c] === 1'b1 && bus.rd_en === 1'b1) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL bytes_timeout client=%0d actual=%0d required=%0d", c, seen, n);
        end
    endtask

    initial begin
        int n1, cyc;
        reset = 1'b1;
        pend  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            clen[i] = '0;
            for (int k = 0; k < 32; k++) cbytes[i][k] = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk("rst_gnt",    32'(bus.gnt), 0);
        chk("rst_done",   32'(bus.done), 0);
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_rd_en",  32'(bus.rd_en), 0);
        chk("rst_dv",     32'({bus.csum_dv_even, bus.csum_dv_odd}), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_clr",    32'(bus.csum_reset), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_clr", 32'(bus.csum_reset), 0);

        // Basic even/odd, odd-length pad, end-around carry
        chk_strobe = 1'b1;
        cbytes[0][0] = 8'h12; cbytes[0][1] = 8'h34;
        run_xfer(0, 2, 16'hEDCB);
        cbytes[2][0] = 8'h12; cbytes[2][1] = 8'h34; cbytes[2][2] = 8'h56;
        run_xfer(2, 3, 16'h97CB);
        cbytes[0][0] = 8'hFF; cbytes[0][1] = 8'hFF; cbytes[0][2] = 8'h00; cbytes[0][3] = 8'h01;
        run_xfer(0, 4, 16'hFFFE);
        chk_strobe = 1'b0;

        // Held requests from clients 1 and 3 alternate
        cbytes[1][0] = 8'h01; cbytes[1][1] = 8'h02; clen[1] = LEN_W'(2);
        cbytes[3][0] = 8'h10; cbytes[3][1] = 8'h20; clen[3] = LEN_W'(2);
        exp_q.push_back('{done: 4'b0010, result: 16'hFEFD});
        exp_q.push_back('{done: 4'b1000, result: 16'hEFDF});
        exp_q.push_back('{done: 4'b0010, result: 16'hFEFD});
        @(negedge clk);
        pend = 4'b1010;
        n1 = 0;
        cyc = 0;
        while (n1 < 2 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.done[1] === 1'b1) n1++;
        end
        pend = '0;
        chk("rr_second_client1_done", 32'(n1), 2);

        // Zero length
        run_xfer(2, 0, CSUM_EMPTY);

        // Reset in the middle of a long transfer
        for (int k = 0; k < 20; k++) cbytes[1][k] = 8'(k + 1);
        clen[1] = LEN_W'(20);
        @(negedge clk);
        pend[1] = 1'b1;
        wait_bytes(1, 5);
        reset = 1'b1;
        pend  = '0;
        @(negedge clk);
        chk("mid_rst_gnt",    32'(bus.gnt), 0);
        chk("mid_rst_busy",   32'(bus.busy), 0);
        chk("mid_rst_done",   32'(bus.done), 0);
        chk("mid_rst_result", 32'(bus.result), 0);
        chk("mid_rst_clr",    32'(bus.csum_reset), 1);
        reset = 1'b0;
        @(negedge clk);
        cbytes[0][0] = 8'hAB; cbytes[0][1] = 8'hCD;
        run_xfer(0, 2, 16'h5432);

`ifdef IP_CSUM_SCHED_ABORT_EN
        // Client 1 withdraws during FEED; client 3 follows
        clen[1] = LEN_W'(10);
        cbytes[3][0] = 8'h0F; cbytes[3][1] = 8'hF0;
        exp_q.push_back('{done: 4'b1000, result: 16'hF00F});
        @(negedge clk);
        pend = 4'b1010;
        wait_bytes(1, 5);
        pend[1] = 1'b0;
        @(negedge clk);
        chk("abort_pulse",  32'(bus.abort), 1);
        chk("abort_gnt",    32'(bus.gnt), 0);
        chk("abort_result", 32'(bus.result), 32'h5432);
        cyc = 0;
        while (bus.done[3] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        pend = '0;
        chk("abort_next_done", 32'(bus.done[3]), 1);
        chk("abort_count", 32'(abort_cnt), 1);
`endif

        repeat (5) @(negedge clk);
        chk("exp_q_drained",  32'(exp_q.size()), 0);
        chk("beat_q_drained", 32'(beat_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
